// File: rtl/mmio_cpl_tx_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC AXI-S TX streams onto one registered TX stream.
// The grant holds from a packet's first beat until its tlast beat is taken into the output register.
module mmio_cpl_tx_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0]                 i_tvalid,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]     i_tdata,
  input  logic [NUM_SRC*(TDATA_WIDTH/8)-1:0] i_tkeep,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]     i_tuser,
  input  logic [NUM_SRC-1:0]                 i_tlast,
  output logic [NUM_SRC-1:0]                 o_src_tready,
  output logic                               o_tvalid,
  output logic [TDATA_WIDTH-1:0]             o_tdata,
  output logic [TDATA_WIDTH/8-1:0]           o_tkeep,
  output logic [TUSER_WIDTH-1:0]             o_tuser,
  output logic                               o_tlast,
  input  logic                               i_tready,
  output logic [NUM_SRC-1:0]                 o_grant
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(NUM_SRC);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  function automatic idx_t rr_next(input idx_t idx);
    return (idx == idx_t'(NUM_SRC - 1)) ? '0 : idx + idx_t'(1);
  endfunction

  state_t             state_q, state_d;
  idx_t               rr_ptr_q, rr_ptr_d;
  idx_t               lock_idx_q, lock_idx_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;

  logic                   tvalid_q;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0]  tkeep_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
  logic                   tlast_q;

  logic [TDATA_WIDTH-1:0] src_tdata [NUM_SRC];
  logic [KEEP_WIDTH-1:0]  src_tkeep [NUM_SRC];
  logic [TUSER_WIDTH-1:0] src_tuser [NUM_SRC];

  logic win_found;
  idx_t win_idx;
  idx_t sel_idx;
  logic sel_req;
  logic load;
  logic ready_en;
  logic accept;
  logic sel_last;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_tdata[gi]    = i_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
    assign src_tkeep[gi]    = i_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
    assign src_tuser[gi]    = i_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH];
    assign o_src_tready[gi] = ready_en && (sel_idx == idx_t'(gi));
  end

  // Round-robin scan: first valid source at or after rr_ptr, wrapping.
  always_comb begin
    idx_t scan_idx;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && i_tvalid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = rr_next(scan_idx);
    end
  end

  assign load     = ~tvalid_q | i_tready;
  assign sel_idx  = (state_q == ST_LOCKED) ? lock_idx_q : win_idx;
  assign sel_req  = (state_q == ST_LOCKED) ? 1'b1 : win_found;
  assign ready_en = rst_n & load & sel_req;
  assign accept   = ready_en & i_tvalid[sel_idx];
  assign sel_last = i_tlast[sel_idx];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    grant_d    = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_ptr_d = rr_next(win_idx);
          end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = win_idx;
            grant_d    = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (accept && sel_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = rr_next(lock_idx_q);
          grant_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      grant_q    <= grant_d;
    end
  end

  // Payload only moves on an accepted beat; an idle load just clears tvalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load) begin
      tvalid_q <= accept;
      if (accept) begin
        tdata_q <= src_tdata[sel_idx];
        tkeep_q <= src_tkeep[sel_idx];
        tuser_q <= src_tuser[sel_idx];
        tlast_q <= sel_last;
      end
    end
  end

  assign o_tvalid = tvalid_q;
  assign o_tdata  = tdata_q;
  assign o_tkeep  = tkeep_q;
  assign o_tuser  = tuser_q;
  assign o_tlast  = tlast_q;
  assign o_grant  = grant_q;

endmodule

// File: doc/mmio_cpl_tx_arbiter.md
# mmio_cpl_tx_arbiter

Packet-atomic round-robin arbiter that merges up to NUM_SRC PCIe SS AXI-S TX streams into one upstream TX stream. It sits between several MMIO completion sources (per-PF/VF response bridges, error-completion generators) and the single PCIe SS TX port. A granted source owns the output until its tlast beat is accepted. Beats are then registered onto the output, with one cycle of latency and full throughput.

## Interface
Parameters:
- NUM_SRC, 4: number of source streams (2..8).
- TDATA_WIDTH, 512: tdata width per stream.
- TUSER_WIDTH, 10: tuser_vendor width per stream.

Ports (flattened buses: source k occupies slice k):
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- i_tvalid  in  NUM_SRC  per-source tvalid.
- i_tdata  in  NUM_SRC*TDATA_WIDTH  per-source tdata.
- i_tkeep  in  NUM_SRC*TDATA_WIDTH/8  per-source tkeep.
- i_tuser  in  NUM_SRC*TUSER_WIDTH  per-source tuser_vendor.
- i_tlast  in  NUM_SRC  per-source tlast.
- o_src_tready  out  NUM_SRC  per-source tready.
- o_tvalid  out  1  merged tvalid (registered).
- o_tdata  out  TDATA_WIDTH  merged tdata (registered).
- o_tkeep  out  TDATA_WIDTH/8  merged tkeep (registered).
- o_tuser  out  TUSER_WIDTH  merged tuser_vendor (registered).
- o_tlast  out  1  merged tlast (registered).
- i_tready  in  1  upstream tready.
- o_grant  out  NUM_SRC  one-hot owner of the in-progress multi-beat packet; 0 when idle (registered).

## Operation
- load = ~o_tvalid | i_tready. The output register accepts a beat only when load = 1.
- State: IDLE or LOCKED. Registers: lock_idx, rr_ptr (width clog2(NUM_SRC)).
- IDLE:
  - Winner = first k with i_tvalid[k], scanning from rr_ptr upward with wrap-around.
  - o_src_tready[winner] = load; every other ready = 0. No valid source means all readies are 0.
  - Accepted beat with tlast=1: stay IDLE, rr_ptr <= (winner+1) mod NUM_SRC.
  - Accepted beat with tlast=0: go to LOCKED, lock_idx <= winner, o_grant <= onehot(winner).
- LOCKED:
  - o_src_tready[lock_idx] = load; all other readies = 0. Other sources' valids are ignored.
  - Accepted beat with tlast=1: go to IDLE, rr_ptr <= (lock_idx+1) mod NUM_SRC, o_grant <= 0.
- Output register: on load, o_tvalid <= (a beat is accepted this cycle), and tdata/tkeep/tuser/tlast <= the accepted source's slice. With no accepted beat, only o_tvalid is forced to 0.
- Beats are never dropped, duplicated or reordered within a source. Packets from different sources never interleave.
- A source that keeps tvalid asserted is granted within NUM_SRC-1 packets of the other sources.
- o_src_tready may depend combinationally on i_tvalid (legal AXI-S); it never depends on the source's own tvalid alone.

## Timing
- Reset values: o_tvalid=0, o_tdata=0, o_tkeep=0, o_tuser=0, o_tlast=0, o_grant=0, state=IDLE, rr_ptr=0, lock_idx=0. o_src_tready is 0 while rst_n=0.
- Latency: a beat accepted in cycle N appears on the output in cycle N+1.
- Throughput: 1 beat/cycle while i_tready=1, including back-to-back single-beat packets from different sources with no bubble.
- Switching from one packet's tlast to the next packet (any source) costs 0 idle cycles.
- Backpressure: if o_tvalid=1 and i_tready=0, the output holds stable and every o_src_tready is 0.
- Reset mid-packet: return to IDLE the next cycle with o_tvalid=0 and the partial packet discarded. Sources must be reset by the same rst_n.
- Simultaneous events: a tlast accepted in the same cycle as a new request only updates rr_ptr. The new arbitration uses the updated rr_ptr in the following cycle.

## Test plan
- Single source: src2 sends 1-beat packet, i_tready=1.
  - Required: o_tvalid one cycle later, o_tdata equals src2's data, o_grant stays 0, rr_ptr=3.
- All 4 sources hold 1-beat packets continuously after reset, i_tready=1.
  - Required: output order src0,src1,src2,src3,src0… with one beat/cycle and no bubbles.
- src1 sends a 3-beat packet while src0 and src3 request.
  - Required: o_grant=4'b0010 for beats 1–2, then 3 contiguous src1 beats, then src3, then src0.
- o_tvalid=1 with i_tready held 0 for 5 cycles.
  - Required: output stable, all o_src_tready=0; on release, beats resume with none lost or duplicated.
- rst_n pulsed low at beat 2 of a 4-beat src0 packet.
  - Required: next cycle o_tvalid=0, o_grant=0, state IDLE; a following src1 packet is granted first (rr_ptr=0 scan finds src1).
- Random valids/tready/lengths over 10k cycles.
  - Required: per-source scoreboard matches exactly, no interleaving, wait bounded by NUM_SRC-1 packets.
